// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line timing, the bit-period formula and receiver FSM states.
package uart_rx_pkg;

  localparam int unsigned SYS_CLK_DEFAULT  = 25_000_000;
  localparam int unsigned BAUDRATE_DEFAULT = 115200;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned sys_clk,
                                               input int unsigned baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side bus of the UART receiver: register select, read data, cycle/write strobes, interrupt.
interface uart_rx_if;
  logic       i_adr;
  logic       i_cyc;
  logic       i_we;
  logic [7:0] o_dat;
  logic       o_int;

  modport slave  (input  i_adr, i_cyc, i_we, output o_dat, o_int);
  modport master (output i_adr, i_cyc, i_we, input  o_dat, o_int);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input with a configurable reset value.
module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register, status flags and a byte-ready pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned SYS_CLK  = SYS_CLK_DEFAULT,
  parameter int unsigned BAUDRATE = BAUDRATE_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_reset,
  uart_rx_if.slave  bus,
  input  logic      rx
);

  localparam int unsigned TICK  = clks_per_bit(SYS_CLK, BAUDRATE);
  localparam int unsigned HALF  = TICK / 2;
  localparam logic [8:0]  TICK9 = 9'(TICK);
  localparam logic [8:0]  HALF9 = 9'(HALF);

  if (TICK > 511 || TICK < 4) begin : g_bad_tick
    $error("uart_rx: clocks per bit out of range for the 9-bit baud counter");
  end

  logic       rx_s;
  rx_state_e  state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] holding_q, holding_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       int_q, int_d;
  logic       data_rd;
  logic       restart;

  uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .d       (rx),
    .q       (rx_s)
  );

  assign data_rd = bus.i_cyc & ~bus.i_we & ~bus.i_adr;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    holding_d   = holding_q;
    valid_d     = valid_q & ~data_rd;
    overrun_d   = overrun_q & ~data_rd;
    frame_err_d = frame_err_q & ~data_rd;
    int_d       = 1'b0;
    restart     = 1'b0;

    unique case (state_q)
      S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
      S_IDLE:      if (!rx_s) state_d = S_START;
      S_START: begin
        bit_idx_d = '0;
        if (cnt_q == HALF9) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        // each bit sample restarts the counter as if re-entering DATA
        if (cnt_q == TICK9) begin
          shreg_d[bit_idx_q] = rx_s;
          restart            = 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == TICK9) begin
          if (rx_s) begin
            state_d = S_IDLE;
            // a data read in this same cycle frees the holding register
            if (!valid_q || data_rd) begin
              holding_d = shreg_q;
              valid_d   = 1'b1;
              int_d     = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase

    cnt_d = (state_d != state_q || restart) ? '0 : cnt_q + 9'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_WAIT_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      holding_q   <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      holding_q   <= holding_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      int_q       <= int_d;
    end
  end

  assign bus.o_dat = bus.i_adr ? {5'b0, frame_err_q, overrun_q, valid_q} : holding_q;
  assign bus.o_int = int_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 25 MHz / 115200 baud (217 clocks per bit).
module tb_uart_rx;

  localparam int TICK = 217;
  localparam int HALF = TICK / 2;
  // clocks from the start-bit drive to the edge where the stop bit is judged, minus one
  localparam int READ_AT = 4 + HALF + 9 * (TICK + 1) - 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_read;
    int         exp_ints;
    logic [7:0] exp_status;
    logic [7:0] exp_data;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic rx = 1'b1;
  int   cyc_cnt = 0;
  int   int_cnt = 0;
  int   fall_cyc = 0;
  int   errors = 0;
  int   checks = 0;

  uart_rx_if bus();

  uart_rx #(.SYS_CLK(25_000_000), .BAUDRATE(115200)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus),
    .rx      (rx)
  );

  always #20 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_cnt = cyc_cnt + 1;
  always @(negedge i_clk) if (bus.o_int) int_cnt = int_cnt + 1;

  task automatic clocks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic peek_status(output logic [7:0] v);
    bus.i_adr = 1'b1;
    #1 v = bus.o_dat;
    bus.i_adr = 1'b0;
  endtask

  task automatic data_read(output logic [7:0] v);
    bus.i_adr = 1'b0;
    bus.i_we  = 1'b0;
    bus.i_cyc = 1'b1;
    #1 v = bus.o_dat;
    clocks(1);
    bus.i_cyc = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc_cnt;
    clocks(TICK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clocks(TICK);
    end
    rx = stop;
    clocks(TICK);
    rx = 1'b1;
    clocks(TICK);
  endtask

  vec_t vecs[6];
  logic [7:0] v;
  logic [7:0] rd_v;
  int base;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 1, 8'h01, 8'h55};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 1, 8'h01, 8'hA3};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 0, 8'h04, 8'hA3};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1, 8'h01, 8'h12};
    vecs[4] = '{8'h11, 1'b1, 1'b0, 1, 8'h01, 8'h00};
    vecs[5] = '{8'h22, 1'b1, 1'b1, 0, 8'h03, 8'h11};

    bus.i_adr = 1'b0;
    bus.i_cyc = 1'b0;
    bus.i_we  = 1'b0;
    clocks(5);
    i_reset = 1'b0;
    clocks(5);

    check("reset_int", int'(bus.o_int), 0);
    peek_status(v);
    check("reset_status", int'(v), 8'h00);
    #1 check("reset_data", int'(bus.o_dat), 8'h00);
    clocks(10);

    for (int i = 0; i < 6; i++) begin
      base = int_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_ints", i), int_cnt - base, vecs[i].exp_ints);
      peek_status(v);
      check($sformatf("vec%0d_status", i), int'(v), int'(vecs[i].exp_status));
      if (vecs[i].do_read) begin
        data_read(v);
        check($sformatf("vec%0d_data", i), int'(v), int'(vecs[i].exp_data));
        peek_status(v);
        check($sformatf("vec%0d_status_after", i), int'(v), 8'h00);
      end
    end

    // short low glitch in IDLE must be rejected without flags
    base = int_cnt;
    rx = 1'b0;
    clocks(50);
    rx = 1'b1;
    clocks(300);
    check("glitch_ints", int_cnt - base, 0);
    peek_status(v);
    check("glitch_status", int'(v), 8'h00);
    base = int_cnt;
    send_frame(8'h5A, 1'b1);
    check("post_glitch_ints", int_cnt - base, 1);
    data_read(v);
    check("post_glitch_data", int'(v), 8'h5A);

    // data read lands in the same cycle the second byte's stop bit is accepted
    send_frame(8'h66, 1'b1);
    peek_status(v);
    check("race_pre_status", int'(v), 8'h01);
    base = int_cnt;
    fork
      send_frame(8'h99, 1'b1);
      begin
        #2;
        clocks(READ_AT);
        data_read(rd_v);
      end
    join
    check("race_ints", int_cnt - base, 1);
    check("race_read_old", int'(rd_v), 8'h66);
    peek_status(v);
    check("race_status", int'(v), 8'h01);
    data_read(v);
    check("race_data", int'(v), 8'h99);
    peek_status(v);
    check("race_status_after", int'(v), 8'h00);

    // reset in the middle of DATA with the line stuck low
    base = int_cnt;
    rx = 1'b0;
    clocks(600);
    i_reset = 1'b1;
    clocks(2);
    i_reset = 1'b0;
    clocks(2500);
    rx = 1'b1;
    clocks(300);
    check("rst_mid_ints", int_cnt - base, 0);
    base = int_cnt;
    send_frame(8'h7E, 1'b1);
    check("rst_next_ints", int_cnt - base, 1);
    data_read(v);
    check("rst_next_data", int'(v), 8'h7E);
    peek_status(v);
    check("rst_status_after", int'(v), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
